prog_addr_decoder: RTL and testbench

Parametrised, run-time programmable successor to the fixed Z80 memory-map decoder. Decodes the Z80 control bus into memrd/memwr/iord/iowr/inta strobes and drives NUM_REGIONS one-hot region enables. Each region's page base, page mask, enable and wait-state count sit in registers the CPU programs through an I/O-port window. A per-cycle wait-state counter drives the CPU wait_n pin so slow devices can be mapped anywhere.

---
 rtl/prog_addr_decoder.sv | 193 +++++++++++++++++++
 tb/tb_prog_addr_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_addr_decoder.sv
// prog_addr_decoder: Z80 control-bus strobe decoder with run-time programmable
// page regions, an I/O-port configuration window and a wait-state generator.
module prog_addr_decoder #(
  parameter int          NUM_REGIONS = 8,
  parameter logic [7:0]  CFG_IO_BASE = 8'hC0,
  parameter logic [2:0]  RESET_WS    = 3'd2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            addr,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   m1_n,
  input  logic                   disable_decode,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   data_oe,
  output logic                   memrd,
  output logic                   memwr,
  output logic                   iord,
  output logic                   iowr,
  output logic                   inta,
  output logic [NUM_REGIONS-1:0] region_ena,
  output logic                   region_hit,
  output logic                   wait_n
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  // Per-region configuration
  logic [7:0] r_base [NUM_REGIONS];
  logic [7:0] r_mask [NUM_REGIONS];
  logic       r_en   [NUM_REGIONS];
  logic [2:0] r_ws   [NUM_REGIONS];

  logic       r_cfg_lvl_q;
  logic       r_memcyc_q;
  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_wait_n;

  logic                   w_win_hit;
  logic                   w_cfg_lvl;
  logic                   w_cfg_we;
  logic [3:0]             w_reg_idx;
  logic [1:0]             w_fld;
  logic [NUM_REGIONS-1:0] w_match;
  logic [NUM_REGIONS-1:0] w_ena;
  logic [2:0]             w_win_ws;
  logic                   w_found;
  logic [7:0]             w_rd_data;
  logic                   w_memcyc;
  logic                   w_unused;

  // CTRL bits [6:3] are not stored; they always read back as zero.
  assign w_unused = ^data_in[6:3];

  assign memrd = ~rd_n & ~mreq_n;
  assign memwr = ~wr_n & ~mreq_n;
  assign iord  = ~rd_n & ~iorq_n & m1_n;
  assign iowr  = ~wr_n & ~iorq_n;
  assign inta  = ~m1_n & ~iorq_n;

  // Config window decodes only addr[7:6]; the upper address byte is ignored.
  assign w_win_hit = (addr[7:6] == CFG_IO_BASE[7:6]);
  assign w_reg_idx = addr[5:2];
  assign w_fld     = addr[1:0];
  assign w_cfg_lvl = iowr & w_win_hit;
  // Only the first sampled edge of an I/O write commits, so a long OUT with
  // wait states never writes twice.
  assign w_cfg_we  = w_cfg_lvl & ~r_cfg_lvl_q & ~disable_decode;

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_match
    assign w_match[gi] = r_en[gi] && (((addr[15:8] ^ r_base[gi]) & r_mask[gi]) == 8'h00);
  end

  // Lowest-index matching region wins; winner's wait-state count is forwarded
  always_comb begin
    w_ena    = '0;
    w_win_ws = 3'd0;
    w_found  = 1'b0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (w_match[r] && !w_found) begin
        w_ena[r] = 1'b1;
        w_win_ws = r_ws[r];
        w_found  = 1'b1;
      end
    end
    if (disable_decode) begin
      w_ena    = '0;
      w_win_ws = 3'd0;
    end
  end

  assign region_ena = w_ena;
  assign region_hit = |w_ena;

  // Config readback mux; unimplemented regions and the reserved field read 0
  always_comb begin
    w_rd_data = 8'h00;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (w_reg_idx == 4'(r)) begin
        case (w_fld)
          2'd0:    w_rd_data = r_base[r];
          2'd1:    w_rd_data = r_mask[r];
          2'd2:    w_rd_data = {r_en[r], 4'b0000, r_ws[r]};
          default: w_rd_data = 8'h00;
        endcase
      end
    end
  end

  assign data_oe  = iord & w_win_hit & ~disable_decode;
  assign data_out = data_oe ? w_rd_data : 8'h00;

  // Configuration registers and the I/O write edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_lvl_q <= 1'b0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
        r_base[r] <= 8'h00;
        r_mask[r] <= 8'h00;
        r_en[r]   <= (r == 0);
        r_ws[r]   <= (r == 0) ? RESET_WS : 3'd0;
      end
    end else begin
      r_cfg_lvl_q <= w_cfg_lvl;
      for (int r = 0; r < NUM_REGIONS; r++) begin
        if (w_cfg_we && (w_reg_idx == 4'(r))) begin
          case (w_fld)
            2'd0: r_base[r] <= data_in;
            2'd1: r_mask[r] <= data_in;
            2'd2: begin
              r_en[r] <= data_in[7];
              r_ws[r] <= data_in[2:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign w_memcyc = (memrd | memwr) & region_hit;

  // Wait-state FSM; wait_n is registered and low exactly while in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_memcyc_q <= 1'b0;
      r_wait_n   <= 1'b1;
    end else begin
      r_memcyc_q <= w_memcyc;
      if (!w_memcyc) begin
        r_state  <= ST_IDLE;
        r_cnt    <= 3'd0;
        r_wait_n <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!r_memcyc_q) begin
              r_cnt <= w_win_ws;
              if (w_win_ws != 3'd0) begin
                r_state  <= ST_WAIT;
                r_wait_n <= 1'b0;
              end else begin
                r_state <= ST_HOLD;
              end
            end
          end
          ST_WAIT: begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              r_state  <= ST_HOLD;
              r_wait_n <= 1'b1;
            end
          end
          ST_HOLD: ;
          default: begin
            r_state  <= ST_IDLE;
            r_wait_n <= 1'b1;
          end
        endcase
      end
    end
  end

  assign wait_n = r_wait_n;

endmodule

// File: tb/tb_prog_addr_decoder.sv
// Self-checking bench for prog_addr_decoder: stimulus pushes expectations into
// a scoreboard queue, a negedge monitor pops and compares them.
module tb_prog_addr_decoder;
  localparam int NR = 8;
  localparam int K_ENA = 0, K_HIT = 1, K_WAIT = 2, K_DOE = 3, K_DOUT = 4, K_STB = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        rd_n, wr_n, mreq_n, iorq_n, m1_n, disable_decode;
  logic [7:0]  data_in, data_out;
  logic        data_oe, memrd, memwr, iord, iowr, inta, region_hit, wait_n;
  logic [NR-1:0] region_ena;

  always #5 clk = ~clk;

  prog_addr_decoder #(.NUM_REGIONS(NR), .CFG_IO_BASE(8'hC0), .RESET_WS(3'd2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .disable_decode(disable_decode),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .memrd(memrd), .memwr(memwr), .iord(iord), .iowr(iowr), .inta(inta),
    .region_ena(region_ena), .region_hit(region_hit), .wait_n(wait_n)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: register file as seen by the CPU
  logic [7:0] m_base [16];
  logic [7:0] m_mask [16];
  logic [7:0] m_ctrl [16];
  logic       m_dis;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int kind, logic [15:0] exp, string name);
    chk_t c;
    c.cyc = cyc; c.kind = kind; c.exp = exp; c.name = name;
    sb.push_back(c);
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 16; r++) begin
      m_base[r] = 8'h00; m_mask[r] = 8'h00; m_ctrl[r] = 8'h00;
    end
    m_ctrl[0] = 8'h82;
  endfunction

  function automatic void model_write(logic [7:0] a, logic [7:0] d);
    int r;
    r = int'(a[5:2]);
    if (m_dis || a[7:6] != 2'b11 || r >= NR) return;
    case (a[1:0])
      2'd0: m_base[r] = d;
      2'd1: m_mask[r] = d;
      2'd2: m_ctrl[r] = d & 8'h87;
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] model_rd(logic [7:0] a);
    int r;
    r = int'(a[5:2]);
    if (r >= NR) return 8'h00;
    case (a[1:0])
      2'd0: return m_base[r];
      2'd1: return m_mask[r];
      2'd2: return m_ctrl[r];
      default: return 8'h00;
    endcase
  endfunction

  function automatic int model_win(logic [15:0] a);
    if (m_dis) return -1;
    for (int r = 0; r < NR; r++)
      if (m_ctrl[r][7] && (((a[15:8] ^ m_base[r]) & m_mask[r]) == 8'h00)) return r;
    return -1;
  endfunction

  function automatic logic [15:0] ena_of(int w);
    return (w < 0) ? 16'h0000 : (16'h0001 << w);
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle
  always @(negedge clk) begin
    chk_t        c;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      c = sb.pop_front();
      case (c.kind)
        K_ENA:   act = 16'(region_ena);
        K_HIT:   act = {15'd0, region_hit};
        K_WAIT:  act = {15'd0, wait_n};
        K_DOE:   act = {15'd0, data_oe};
        K_DOUT:  act = {8'd0, data_out};
        default: act = {11'd0, memrd, memwr, iord, iowr, inta};
      endcase
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    addr = {8'($urandom), a}; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
    model_write(a, d);
    tick();
    idle();
    tick();
    $display("io_write  port=%02h data=%02h", a, d);
  endtask

  task automatic io_read(input logic [7:0] a);
    logic oe;
    oe = !m_dis && (a[7:6] == 2'b11);
    addr = {8'($urandom), a}; iorq_n = 1'b0; rd_n = 1'b0;
    push(K_DOE, {15'd0, oe}, "rd_oe");
    push(K_DOUT, oe ? {8'd0, model_rd(a)} : 16'h0000, "rd_data");
    push(K_STB, 16'h0004, "rd_strobes");
    tick();
    idle();
    push(K_DOE, 16'h0000, "rd_oe_off");
    push(K_DOUT, 16'h0000, "rd_data_off");
    tick();
    $display("io_read   port=%02h expect=%02h oe=%0b", a, model_rd(a), oe);
  endtask

  task automatic addr_check(input logic [15:0] a);
    int w;
    w = model_win(a);
    addr = a;
    push(K_ENA, ena_of(w), "decode_ena");
    push(K_HIT, {15'd0, w >= 0}, "decode_hit");
    tick();
    $display("decode    addr=%04h region=%0d", a, w);
  endtask

  task automatic mem_cycle(input logic [15:0] a, input int n);
    int w, ws;
    w  = model_win(a);
    ws = (w < 0) ? 0 : int'(m_ctrl[w][2:0]);
    addr = a; mreq_n = 1'b0; rd_n = 1'b0;
    push(K_ENA, ena_of(w), "mem_ena");
    push(K_HIT, {15'd0, w >= 0}, "mem_hit");
    push(K_STB, 16'h0010, "mem_strobes");
    for (int k = 1; k <= n; k++) begin
      tick();
      push(K_WAIT, (w >= 0 && k <= ws) ? 16'h0000 : 16'h0001, "mem_wait_n");
    end
    idle();
    tick();
    push(K_WAIT, 16'h0001, "mem_wait_release");
    $display("mem_read  addr=%04h region=%0d ws=%0d clocks=%0d", a, w, ws, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b, m, c, ra;
    logic [15:0] a;
    int          r;

    rst_n = 1'b0; disable_decode = 1'b0; data_in = 8'h00; addr = 16'h0000;
    m_dis = 1'b0;
    idle();
    model_reset();
    tick(); tick();
    push(K_WAIT, 16'h0001, "reset_wait_n");
    push(K_DOE, 16'h0000, "reset_data_oe");
    push(K_DOUT, 16'h0000, "reset_data_out");
    push(K_ENA, 16'h0001, "reset_ena");
    push(K_STB, 16'h0000, "reset_strobes");
    tick();
    rst_n = 1'b1;
    tick();
    push(K_ENA, 16'h0001, "post_reset_ena");
    push(K_HIT, 16'h0001, "post_reset_hit");
    push(K_WAIT, 16'h0001, "post_reset_wait_n");
    mem_cycle(16'($urandom), 4);

    // Region 0 narrowed to page 70, region 1 at 6x
    io_write(8'hC0, 8'h70);
    io_write(8'hC1, 8'hFF);
    io_write(8'hC4, 8'h60);
    io_write(8'hC5, 8'hF0);
    io_write(8'hC6, 8'h80);
    mem_cycle(16'h6ABC, 3);
    mem_cycle(16'h7000, 4);
    for (int i = 4; i < 8; i++) io_read(8'(8'hC0 + i));

    // Priority with overlapping pages, then region 0 disabled
    io_write(8'hC0, 8'h40); io_write(8'hC1, 8'hC0); io_write(8'hC2, 8'h81);
    io_write(8'hCC, 8'h40); io_write(8'hCD, 8'hE0); io_write(8'hCE, 8'h83);
    mem_cycle(16'h4123, 3);
    io_write(8'hC2, 8'h00);
    mem_cycle(16'h4123, 5);
    mem_cycle(16'h8000, 3);

    // Abort after 3 of 7 waits, then a full cycle
    io_write(8'hC8, 8'h20); io_write(8'hC9, 8'hFF); io_write(8'hCA, 8'h87);
    mem_cycle(16'h2000, 3);
    mem_cycle(16'h2000, 9);

    // Held OUT writes only its first sampled value
    addr = {8'h00, 8'hC2}; iorq_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'($urandom);
      if (i == 0) model_write(8'hC2, data_in);
      tick();
    end
    idle(); tick();
    $display("io_write  port=C2 held 5 clocks");
    io_read(8'hC2);

    // Interrupt acknowledge in the window: no readback drive, no write
    addr = {8'h00, 8'hC0}; m1_n = 1'b0; iorq_n = 1'b0;
    push(K_DOE, 16'h0000, "inta_data_oe");
    push(K_STB, 16'h0001, "inta_strobes");
    tick(); idle(); tick();
    $display("inta      port=C0");
    io_read(8'hC0);
    io_read(8'hE1);

    // disable_decode blocks decode and config access
    m_dis = 1'b1; disable_decode = 1'b1;
    addr_check(16'h2000);
    io_write(8'hC5, 8'h11);
    io_read(8'hC5);
    mem_cycle(16'h2000, 3);
    m_dis = 1'b0; disable_decode = 1'b0;
    io_read(8'hC5);

    // Randomised programming and decode
    for (int it = 0; it < 8; it++) begin
      r  = $urandom_range(0, NR - 1);
      ra = 8'(8'hC0 + r * 4);
      b  = 8'($urandom); m = 8'($urandom); c = 8'($urandom);
      if ($urandom_range(0, 1) == 1) m = m & 8'hF0;
      io_write(ra, b);
      io_write(8'(ra + 1), m);
      io_write(8'(ra + 2), c);
      addr_check(16'($urandom));
      a = {b ^ (8'($urandom) & ~m), 8'($urandom)};
      addr_check(a);
      mem_cycle(a, 9);
      io_read(8'(8'hC0 + $urandom_range(0, 63)));
    end

    // Reset while wait_n is low
    io_write(8'hC0, 8'h70); io_write(8'hC1, 8'hFF); io_write(8'hC2, 8'h83);
    addr = 16'h7000; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    push(K_WAIT, 16'h0000, "pre_reset_wait_n");
    tick();
    rst_n = 1'b0;
    #1;
    push(K_WAIT, 16'h0001, "async_reset_wait_n");
    model_reset();
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    io_read(8'hC2);
    io_read(8'hC6);
    io_read(8'hC0);

    tick(); tick();
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
